// File: rtl/smart_row_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : smart_row_feeder_if
// Brief    : Loader-side and MAC-row-side signal bundle of the smart row feeder.
// Revision : 1.0  initial release
// ============================================================================
interface smart_row_feeder_if #(
    parameter int WORD_SIZE  = 16,
    parameter int FIFO_DEPTH = 8
);
    localparam int c_LW = $clog2(FIFO_DEPTH) + 1;

    logic [WORD_SIZE-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 start;
    logic [7:0]           run_len;
    logic                 mode_smart;
    logic [WORD_SIZE-1:0] left_out;
    logic [WORD_SIZE-1:0] horizontal_smart_bus_out;
    logic                 select_left_in_smart;
    logic                 out_valid;
    logic                 busy;
    logic                 done;
    logic                 underflow;
    logic [c_LW-1:0]      fifo_level;
    logic [7:0]           underflow_count;

    modport master (
        output in_data, in_valid, start, run_len, mode_smart,
        input  in_ready, left_out, horizontal_smart_bus_out, select_left_in_smart,
        input  out_valid, busy, done, underflow, fifo_level, underflow_count
    );

    modport slave (
        input  in_data, in_valid, start, run_len, mode_smart,
        output in_ready, left_out, horizontal_smart_bus_out, select_left_in_smart,
        output out_valid, busy, done, underflow, fifo_level, underflow_count
    );
endinterface
`default_nettype wire

// File: rtl/smart_row_feeder.sv
`default_nettype none
// ============================================================================
// Module   : smart_row_feeder
// Brief    : Operand FIFO + skewed burst streamer feeding the first MAC of a row.
//            Define SMART_FEEDER_UNDERFLOW_CNT_EN to enable the bubble counter.
// Revision : 1.0  initial release
// ============================================================================
module smart_row_feeder #(
    parameter int WORD_SIZE  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int SKEW       = 0
) (
    input  logic              clk,
    input  logic              rst,
    smart_row_feeder_if.slave bus
);
    localparam int              c_AW    = $clog2(FIFO_DEPTH);
    localparam int              c_LW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_LW-1:0] c_FULL  = c_LW'(FIFO_DEPTH);
    localparam logic [7:0]      c_SKEW  = 8'(SKEW);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SKEW   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_remaining;
    logic [7:0]           w_remaining_nxt;
    logic [7:0]           r_skew_cnt;
    logic [7:0]           w_skew_cnt_nxt;
    logic                 r_mode;
    logic                 w_mode_nxt;
    logic                 w_pop;
    logic                 w_bubble;
    logic                 w_burst_end;

    logic [WORD_SIZE-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_LW-1:0]      r_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;

    logic [WORD_SIZE-1:0] r_left;
    logic [WORD_SIZE-1:0] r_bus;
    logic                 r_sel;
    logic                 r_out_valid;
    logic                 r_done;
    logic                 r_underflow;

    // Full/empty come from the registered count, so a same-cycle pop never
    // makes room for a push and a fresh word is never popped the cycle it lands.
    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid && !w_full;

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_skew_cnt_nxt  = r_skew_cnt;
        w_mode_nxt      = r_mode;
        w_pop           = 1'b0;
        w_bubble        = 1'b0;
        w_burst_end     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && (bus.run_len != 8'd0)) begin
                    w_remaining_nxt = bus.run_len;
                    w_mode_nxt      = bus.mode_smart;
                    if (SKEW > 0) begin
                        w_state_nxt    = S_SKEW;
                        w_skew_cnt_nxt = c_SKEW;
                    end else begin
                        w_state_nxt    = S_STREAM;
                    end
                end
            end
            S_SKEW: begin
                w_skew_cnt_nxt = r_skew_cnt - 8'd1;
                if (r_skew_cnt == 8'd1) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                w_pop           = !w_empty;
                w_bubble        = w_empty;
                w_remaining_nxt = r_remaining - 8'd1;
                if (r_remaining == 8'd1) begin
                    w_state_nxt = S_IDLE;
                    w_burst_end = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_remaining <= 8'd0;
            r_skew_cnt  <= 8'd0;
            r_mode      <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_left      <= '0;
            r_bus       <= '0;
            r_sel       <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_skew_cnt  <= w_skew_cnt_nxt;
            r_mode      <= w_mode_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count     <= r_count + {{(c_LW-1){1'b0}}, w_push} - {{(c_LW-1){1'b0}}, w_pop};
            r_left      <= (w_pop && !r_mode) ? r_mem[r_rd_ptr] : '0;
            r_bus       <= (w_pop &&  r_mode) ? r_mem[r_rd_ptr] : '0;
            r_sel       <= w_pop && r_mode;
            r_out_valid <= w_pop;
            r_done      <= w_burst_end;
            if (w_bubble) begin
                r_underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

`ifdef SMART_FEEDER_UNDERFLOW_CNT_EN
    logic [7:0] r_uf_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_uf_cnt <= 8'd0;
        end else if (w_bubble && (r_uf_cnt != 8'hFF)) begin
            r_uf_cnt <= r_uf_cnt + 8'd1;
        end
    end

    assign bus.underflow_count = r_uf_cnt;
`else
    assign bus.underflow_count = 8'd0;
`endif

    assign bus.in_ready                 = !w_full;
    assign bus.left_out                 = r_left;
    assign bus.horizontal_smart_bus_out = r_bus;
    assign bus.select_left_in_smart     = r_sel;
    assign bus.out_valid                = r_out_valid;
    assign bus.busy                     = (r_state != S_IDLE);
    assign bus.done                     = r_done;
    assign bus.underflow                = r_underflow;
    assign bus.fifo_level               = r_count;
endmodule
`default_nettype wire
